// File: rtl/modport_alu_pkg.sv
// Shared constants, command encodings and result bundle for the registered ALU.
package alu_pkg;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned CMD_W  = 4;

  // Arithmetic command codes (mode = 1); 9..15 are illegal.
  typedef enum logic [CMD_W-1:0] {
    ArAdd    = 4'd0,
    ArSub    = 4'd1,
    ArAddCin = 4'd2,
    ArSubCin = 4'd3,
    ArIncA   = 4'd4,
    ArDecA   = 4'd5,
    ArIncB   = 4'd6,
    ArDecB   = 4'd7,
    ArCmp    = 4'd8
  } arith_cmd_e;

  // Logical command codes (mode = 0); 14..15 are illegal.
  typedef enum logic [CMD_W-1:0] {
    LgAnd   = 4'd0,
    LgNand  = 4'd1,
    LgOr    = 4'd2,
    LgNor   = 4'd3,
    LgXor   = 4'd4,
    LgXnor  = 4'd5,
    LgNotA  = 4'd6,
    LgNotB  = 4'd7,
    LgShr1A = 4'd8,
    LgShl1A = 4'd9,
    LgShr1B = 4'd10,
    LgShl1B = 4'd11,
    LgRolAB = 4'd12,
    LgRorAB = 4'd13
  } logic_cmd_e;

  // inp_valid encodings: bit0 = A valid, bit1 = B valid.
  typedef enum logic [1:0] {
    VldNone  = 2'b00,
    VldAOnly = 2'b01,
    VldBOnly = 2'b10,
    VldBoth  = 2'b11
  } inp_valid_e;

  // Everything the ALU produces for one command.
  typedef struct packed {
    logic [DATA_W:0] res;
    logic            cout;
    logic            oflow;
    logic            err;
    logic            g;
    logic            e;
    logic            l;
  } alu_out_t;

endpackage

// File: rtl/modport_alu_if.sv
// ALU bus: operands/command towards the ALU, registered result and flags back.
interface alu_if;
  import alu_pkg::*;

  logic [DATA_W-1:0] op_a;
  logic [DATA_W-1:0] op_b;
  logic              cin;
  logic              mode;
  logic              ce;
  logic [CMD_W-1:0]  cmd;
  logic [1:0]        inp_valid;

  logic [DATA_W:0]   res;
  logic              cout;
  logic              oflow;
  logic              err;
  logic              G;
  logic              E;
  logic              L;

  modport master (
    output op_a, op_b, cin, mode, ce, cmd, inp_valid,
    input  res, cout, oflow, err, G, E, L
  );

  modport slave (
    input  op_a, op_b, cin, mode, ce, cmd, inp_valid,
    output res, cout, oflow, err, G, E, L
  );

endinterface

// File: rtl/modport_alu_calc.sv
// Combinational ALU core: next result, flags and err for one command.
module alu_calc
  import alu_pkg::*;
(
  input  logic [DATA_W-1:0] op_a,
  input  logic [DATA_W-1:0] op_b,
  input  logic              cin,
  input  logic              mode,
  input  logic [CMD_W-1:0]  cmd,
  input  logic [1:0]        inp_valid,
  output alu_out_t          result
);

  logic [DATA_W:0]     a9;
  logic [DATA_W:0]     b9;
  logic [DATA_W:0]     c9;
  logic [2*DATA_W-1:0] rot_cat;
  logic                need_a;
  logic                need_b;
  logic                bad;

  assign a9 = {1'b0, op_a};
  assign b9 = {1'b0, op_b};
  assign c9 = {{DATA_W{1'b0}}, cin};

  // Decode command, compute result, then force the error shape if anything is wrong.
  always_comb begin
    result  = '0;
    rot_cat = '0;
    need_a  = 1'b1;
    need_b  = 1'b1;
    bad     = 1'b0;
    if (mode) begin
      case (arith_cmd_e'(cmd))
        ArAdd:    begin result.res = a9 + b9;      result.cout  = result.res[DATA_W]; end
        ArSub:    begin result.res = a9 - b9;      result.oflow = (a9 < b9); end
        ArAddCin: begin result.res = a9 + b9 + c9; result.cout  = result.res[DATA_W]; end
        ArSubCin: begin result.res = a9 - b9 - c9; result.oflow = (a9 < b9 + c9); end
        ArIncA: begin
          need_b = 1'b0; result.res = a9 + 9'd1; result.cout = result.res[DATA_W];
        end
        ArDecA: begin
          need_b = 1'b0; result.res = a9 - 9'd1; result.oflow = (op_a == '0);
        end
        ArIncB: begin
          need_a = 1'b0; result.res = b9 + 9'd1; result.cout = result.res[DATA_W];
        end
        ArDecB: begin
          need_a = 1'b0; result.res = b9 - 9'd1; result.oflow = (op_b == '0);
        end
        ArCmp: begin
          result.g = (op_a > op_b);
          result.e = (op_a == op_b);
          result.l = (op_a < op_b);
        end
        default: bad = 1'b1;
      endcase
    end else begin
      case (logic_cmd_e'(cmd))
        LgAnd:   result.res = {1'b0, op_a & op_b};
        LgNand:  result.res = {1'b0, ~(op_a & op_b)};
        LgOr:    result.res = {1'b0, op_a | op_b};
        LgNor:   result.res = {1'b0, ~(op_a | op_b)};
        LgXor:   result.res = {1'b0, op_a ^ op_b};
        LgXnor:  result.res = {1'b0, ~(op_a ^ op_b)};
        LgNotA:  begin need_b = 1'b0; result.res = {1'b0, ~op_a}; end
        LgNotB:  begin need_a = 1'b0; result.res = {1'b0, ~op_b}; end
        LgShr1A: begin need_b = 1'b0; result.res = {2'b00, op_a[DATA_W-1:1]}; end
        LgShl1A: begin need_b = 1'b0; result.res = {1'b0, op_a[DATA_W-2:0], 1'b0}; end
        LgShr1B: begin need_a = 1'b0; result.res = {2'b00, op_b[DATA_W-1:1]}; end
        LgShl1B: begin need_a = 1'b0; result.res = {1'b0, op_b[DATA_W-2:0], 1'b0}; end
        // Rotate via doubled operand; upper nibble of the amount must be clear.
        LgRolAB: begin
          rot_cat    = {op_a, op_a} << op_b[2:0];
          result.res = {1'b0, rot_cat[2*DATA_W-1:DATA_W]};
          bad        = |op_b[7:4];
        end
        LgRorAB: begin
          rot_cat    = {op_a, op_a} >> op_b[2:0];
          result.res = {1'b0, rot_cat[DATA_W-1:0]};
          bad        = |op_b[7:4];
        end
        default: bad = 1'b1;
      endcase
    end
    // Every legal command needs at least one operand, so VldNone always lands here.
    if ((need_a && !inp_valid[0]) || (need_b && !inp_valid[1])) bad = 1'b1;
    if (bad) begin
      result     = '0;
      result.err = 1'b1;
    end
  end

endmodule

// File: rtl/modport_alu.sv
// Registered 8-bit ALU behind alu_if; outputs update on enabled edges only.
// Define ALU_XCHECK_EN to compile X/Z checks on the inputs while out of reset.
module modport_alu
  import alu_pkg::*;
(
  input logic clk,
  input logic rst,
  alu_if.slave bus
);

  alu_out_t out_d;
  alu_out_t out_q;

  alu_calc u_calc (
    .op_a      (bus.op_a),
    .op_b      (bus.op_b),
    .cin       (bus.cin),
    .mode      (bus.mode),
    .cmd       (bus.cmd),
    .inp_valid (bus.inp_valid),
    .result    (out_d)
  );

  // Output register: cleared asynchronously, loaded only when ce is high.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_q <= '0;
    end else if (bus.ce) begin
      out_q <= out_d;
    end
  end

  assign bus.res   = out_q.res;
  assign bus.cout  = out_q.cout;
  assign bus.oflow = out_q.oflow;
  assign bus.err   = out_q.err;
  assign bus.G     = out_q.g;
  assign bus.E     = out_q.e;
  assign bus.L     = out_q.l;

`ifdef ALU_XCHECK_EN
  // Flag unknown inputs on every edge while out of reset.
  always @(posedge clk) begin
    if (rst) begin
      assert (!$isunknown({bus.op_a, bus.op_b, bus.cin, bus.ce, bus.mode,
                           bus.inp_valid, bus.cmd}))
        else $error("modport_alu: X/Z on inputs at time %0t", $time);
    end
  end
`else
  // Input X/Z checks not compiled in this build.
`endif

endmodule

// File: tb/tb_modport_alu.sv
// Self-checking bench for modport_alu: directed steps plus random commands
// checked against an arithmetic reference model.
module tb_modport_alu;
  import alu_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  alu_if bus ();

  modport_alu dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int tests = 0;
  int fails = 0;
  logic [14:0] exp_q = '0;  // {res[8:0], cout, oflow, err, G, E, L}

  // Reference: computes the result from the command rules using integer arithmetic.
  function automatic logic [14:0] model(input logic [7:0] a, input logic [7:0] b,
                                        input logic c, input logic m,
                                        input logic [3:0] cmd, input logic [1:0] v);
    int ia, ib, r, n;
    bit use_a, use_b, cy, bw, ill, g, e, l;
    logic [8:0] rv;
    ia = int'(a); ib = int'(b); r = 0; n = ib % 8;
    cy = 0; bw = 0; ill = 0; g = 0; e = 0; l = 0;
    if (m) begin
      use_a = !(cmd inside {4'd6, 4'd7});
      use_b = !(cmd inside {4'd4, 4'd5});
      case (cmd)
        4'd0: begin r = ia + ib;         cy = (r > 255); end
        4'd1: begin r = ia - ib;         bw = (r < 0);   end
        4'd2: begin r = ia + ib + int'(c); cy = (r > 255); end
        4'd3: begin r = ia - ib - int'(c); bw = (r < 0);   end
        4'd4: begin r = ia + 1;          cy = (r > 255); end
        4'd5: begin r = ia - 1;          bw = (r < 0);   end
        4'd6: begin r = ib + 1;          cy = (r > 255); end
        4'd7: begin r = ib - 1;          bw = (r < 0);   end
        4'd8: begin g = (ia > ib); e = (ia == ib); l = (ia < ib); end
        default: ill = 1;
      endcase
    end else begin
      use_a = !(cmd inside {4'd7, 4'd10, 4'd11});
      use_b = !(cmd inside {4'd6, 4'd8, 4'd9});
      case (cmd)
        4'd0:  r = ia & ib;
        4'd1:  r = 255 - (ia & ib);
        4'd2:  r = ia | ib;
        4'd3:  r = 255 - (ia | ib);
        4'd4:  r = ia ^ ib;
        4'd5:  r = 255 - (ia ^ ib);
        4'd6:  r = 255 - ia;
        4'd7:  r = 255 - ib;
        4'd8:  r = ia / 2;
        4'd9:  r = (ia * 2) % 256;
        4'd10: r = ib / 2;
        4'd11: r = (ib * 2) % 256;
        4'd12: begin r = (ia * (2 ** n)) % 256 + ia / (2 ** (8 - n)); ill = (ib >= 16); end
        4'd13: begin r = ia / (2 ** n) + (ia * (2 ** (8 - n))) % 256; ill = (ib >= 16); end
        default: ill = 1;
      endcase
    end
    if ((use_a && !v[0]) || (use_b && !v[1])) ill = 1;
    if (ill) return 15'h0008;
    rv = r[8:0];
    return {rv, cy, bw, 1'b0, g, e, l};
  endfunction

  function automatic logic [14:0] observed();
    return {bus.res, bus.cout, bus.oflow, bus.err, bus.G, bus.E, bus.L};
  endfunction

  task automatic check(input string tag);
    logic [14:0] o;
    o = observed();
    tests++;
    assert (o === exp_q)
      else begin
        fails++;
        $error("FAIL %s observed=%h expected=%h", tag, o, exp_q);
      end
  endtask

  // Hand-derived result value, independent of the model.
  task automatic check_res(input string tag, input logic [8:0] want);
    tests++;
    assert (bus.res === want)
      else begin
        fails++;
        $error("FAIL %s res observed=%h expected=%h", tag, bus.res, want);
      end
  endtask

  // Drive one cycle (called #1 after a rising edge), then check #1 after the next edge.
  task automatic op(input string tag, input logic [7:0] a, input logic [7:0] b,
                    input logic c, input logic m, input logic en,
                    input logic [3:0] cmd, input logic [1:0] v);
    bus.op_a = a; bus.op_b = b; bus.cin = c; bus.mode = m;
    bus.ce = en; bus.cmd = cmd; bus.inp_valid = v;
    if (en) exp_q = model(a, b, c, m, cmd, v);
    @(posedge clk);
    #1;
    check(tag);
  endtask

  initial begin
    bus.op_a = '0; bus.op_b = '0; bus.cin = 1'b0; bus.mode = 1'b0;
    bus.ce = 1'b0; bus.cmd = '0; bus.inp_valid = 2'b00;
    repeat (2) @(posedge clk);
    #1;
    exp_q = '0;
    check("reset_init");

    rst = 1'b1;
    op("add_first", 8'h10, 8'h20, 1'b0, 1'b1, 1'b1, 4'd0, 2'b11);
    check_res("add_first_lit", 9'h030);

    // Asynchronous reset in the middle of a cycle discards the result.
    op("add_carry", 8'hFF, 8'h01, 1'b0, 1'b1, 1'b1, 4'd0, 2'b11);
    check_res("add_carry_lit", 9'h100);
    #2 rst = 1'b0;
    #1 exp_q = '0;
    check("reset_async");
    @(posedge clk);
    #1 check("reset_held");
    rst = 1'b1;
    op("release_idle", 8'h33, 8'h44, 1'b0, 1'b1, 1'b0, 4'd0, 2'b11);
    op("release_add", 8'h10, 8'h20, 1'b0, 1'b1, 1'b1, 4'd0, 2'b11);
    check_res("release_add_lit", 9'h030);

    op("sub_borrow", 8'h05, 8'h07, 1'b0, 1'b1, 1'b1, 4'd1, 2'b11);
    check_res("sub_borrow_lit", 9'h1FE);
    op("add_cin", 8'h01, 8'h01, 1'b1, 1'b1, 1'b1, 4'd2, 2'b11);
    check_res("add_cin_lit", 9'h003);
    op("sub_cin", 8'h05, 8'h05, 1'b1, 1'b1, 1'b1, 4'd3, 2'b11);
    op("dec_a_zero", 8'h00, 8'h99, 1'b0, 1'b1, 1'b1, 4'd5, 2'b01);
    check_res("dec_a_zero_lit", 9'h1FF);
    op("inc_b_wrap", 8'h00, 8'hFF, 1'b0, 1'b1, 1'b1, 4'd6, 2'b10);
    check_res("inc_b_wrap_lit", 9'h100);
    op("cmp_eq", 8'h42, 8'h42, 1'b0, 1'b1, 1'b1, 4'd8, 2'b11);
    op("cmp_gt", 8'h80, 8'h7F, 1'b0, 1'b1, 1'b1, 4'd8, 2'b11);
    op("nand", 8'hF0, 8'hFF, 1'b0, 1'b0, 1'b1, 4'd1, 2'b11);
    check_res("nand_lit", 9'h00F);
    op("rol", 8'h81, 8'h01, 1'b0, 1'b0, 1'b1, 4'd12, 2'b11);
    check_res("rol_lit", 9'h003);
    op("ror_bad_amt", 8'h81, 8'h11, 1'b0, 1'b0, 1'b1, 4'd13, 2'b11);
    op("add_a_only", 8'h10, 8'h20, 1'b0, 1'b1, 1'b1, 4'd0, 2'b01);
    check_res("add_a_only_lit", 9'h000);
    op("inc_a_a_only", 8'h10, 8'h20, 1'b0, 1'b1, 1'b1, 4'd4, 2'b01);
    check_res("inc_a_lit", 9'h011);
    op("arith_cmd12", 8'h10, 8'h20, 1'b0, 1'b1, 1'b1, 4'd12, 2'b11);
    op("valid_none", 8'h10, 8'h20, 1'b0, 1'b0, 1'b1, 4'd0, 2'b00);

    // Hold with ce low while inputs keep changing.
    op("ce_load", 8'h10, 8'h20, 1'b0, 1'b1, 1'b1, 4'd0, 2'b11);
    for (int i = 0; i < 3; i++) begin
      op("ce_hold", 8'(8'hA0 + i), 8'h5A, 1'b1, 1'b0, 1'b0, 4'(i), 2'b11);
      check_res("ce_hold_lit", 9'h030);
    end

    // Random commands, with occasional ce drops and short rotate amounts.
    for (int i = 0; i < 400; i++) begin
      logic [7:0] ra, rb;
      ra = 8'($urandom);
      rb = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 15)) : 8'($urandom);
      op("random", ra, rb, 1'($urandom), 1'($urandom), ($urandom_range(0, 3) != 0),
         4'($urandom), 2'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Hard stop so a stuck run still terminates.
  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/modport_alu.md
# modport_alu

Registered 8-bit ALU with arithmetic and logical command sets, operand-valid qualification and comparison flags. It sits behind the ALU interface: stimulus is driven just after each rising edge, and results are sampled on the following rising edge. The block evaluates one command per enabled cycle and holds its outputs otherwise.

## Interface
- No parameters; widths are fixed by the package constants (`DATA_W=8`, `CMD_W=4`).
- `clk` in 1 — single clock, rising edge.
- `rst` in 1 — asynchronous, active-low reset.
- `op_a` in 8 — operand A.
- `op_b` in 8 — operand B.
- `cin` in 1 — carry in.
- `mode` in 1 — 1 = arithmetic, 0 = logical.
- `ce` in 1 — clock enable.
- `cmd` in 4 — command code.
- `inp_valid` in 2 — bit0 = A valid, bit1 = B valid.
- `res` out 9 — result; bit 8 is the carry/borrow for arithmetic, 0 for logical.
- `cout` out 1 — carry out.
- `oflow` out 1 — borrow/underflow.
- `err` out 1 — illegal command, missing operand, or bad rotate amount.
- `G`, `E`, `L` out 1 each — compare A>B, A==B, A<B.

## Operation
- Arithmetic commands (`mode=1`):
  - 0 ADD a+b.
  - 1 SUB a−b.
  - 2 ADD_CIN a+b+cin.
  - 3 SUB_CIN a−b−cin.
  - 4 INC_A, 5 DEC_A (A only).
  - 6 INC_B, 7 DEC_B (B only).
  - 8 CMP: res=0, exactly one of G/E/L set.
  - 9–15: err.
- Logical commands (`mode=0`), `res[8]=0`:
  - 0 AND, 1 NAND, 2 OR, 3 NOR, 4 XOR, 5 XNOR (both operands).
  - 6 NOT_A, 8 SHR1_A, 9 SHL1_A (A only).
  - 7 NOT_B, 10 SHR1_B, 11 SHL1_B (B only).
  - 12 ROL_A_B, 13 ROR_A_B: rotate A by `op_b[2:0]`; `op_b[7:4]≠0` → err.
  - 14–15: err.
- Arithmetic width rules: computed at 9 bits.
  - Adds: `cout=res[8]`.
  - Subtracts and decrements: `oflow=1` when the true result is negative; `res` holds the 9-bit two's-complement value.
  - INC/DEC wrap modulo 256 in `res[7:0]`; `res[8]` carries the wrap.
- Operand qualification:
  - `inp_valid=00` → err.
  - A command needing an operand whose valid bit is clear → err.
- On any err: `err=1`, `res=0`, and cout/oflow/G/E/L are 0.
- Every enabled cycle rewrites all outputs. Flags not produced by the command are 0.

## Timing
- Reset (`rst=0`, asynchronous): `res=0` and cout/oflow/err/G/E/L=0 immediately. Outputs stay 0 until the first enabled edge after release.
- Latency is one cycle: inputs captured at edge N appear on the outputs after edge N and are valid for sampling at edge N+1.
- `ce=0`: all outputs hold their previous values; inputs are ignored.
- `ce` is back-to-back capable: a new command may be issued every cycle.
- Reset asserted mid-stream discards the in-flight result. There is no recovery cycle after release.

## Configuration
- `ALU_XCHECK_EN` defined: the block contains immediate assertions at each `clk` rising edge while `rst=1` that flag X/Z on `op_a`, `op_b`, `cin`, `ce`, `mode`, `inp_valid` and `cmd` with `$error`, reporting the time.
- Undefined: no checks are compiled. Function is identical either way.

## Structure
- `alu_pkg` holds:
  - `DATA_W` and `CMD_W`.
  - An enum for arithmetic command codes and an enum for logical command codes.
  - The inp_valid encodings (NONE, A_ONLY, B_ONLY, BOTH).
- Sub-module `alu_calc` is purely combinational: it computes the next res/flags/err from the inputs. The top level registers its outputs under `ce` and async reset.

## Test plan
- Reset: hold `rst=0` mid-operation → all outputs 0 at once. After release, with `ce=1`, ADD 0x10+0x20 → `res=0x030` one cycle later.
- Arithmetic carry and borrow:
  - ADD 0xFF+0x01 → `res=0x100`, `cout=1`.
  - SUB 0x05−0x07 → `oflow=1`, `res=0x1FE`.
  - ADD_CIN 0x01+0x01 with `cin=1` → `res=0x003`.
- Compare: CMP with A=B=0x42 → E=1, G=0, L=0, `res=0`. With A=0x80, B=0x7F → G=1.
- Logical and rotate:
  - NAND 0xF0,0xFF → `res=0x00F`.
  - ROL 0x81 by `op_b=0x01` → `res=0x003`.
  - ROR with `op_b=0x11` → err=1.
- Validity and illegal commands:
  - ADD with `inp_valid=01` → err=1, `res=0`.
  - INC_A with `inp_valid=01` → OK.
  - mode=1, cmd=12 → err.
  - `inp_valid=00` → err.
- Clock enable: load ADD 0x10+0x20 (`res=0x030`), drop `ce` while changing the inputs for 3 cycles → outputs hold `res=0x030`.
